// File: rtl/simmem_delay_releaser.sv
// Per-ID response release scheduler: slot table of delayed descriptors driving per-ID release enables.
// Optional occupancy output enabled by SIMMEM_DELAY_RELEASER_OCCUPANCY_EN.
module simmem_delay_releaser #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [IDWidth-1:0]        req_id_i,
  input  logic [DelayWidth-1:0]     req_delay_i,
  output logic [(2**IDWidth)-1:0]   release_en_o,
`ifdef SIMMEM_DELAY_RELEASER_OCCUPANCY_EN
  output logic [$clog2(NumSlots+1)-1:0] occupancy_o,
`endif
  input  logic                      done_valid_i,
  input  logic [IDWidth-1:0]        done_id_i
);

  localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned NumIds   = 2**IDWidth;

  typedef struct packed {
    logic                  valid;
    logic [IDWidth-1:0]    id;
    logic [DelayWidth-1:0] cnt;
  } slot_t;

  slot_t                slot_q [NumSlots];
  logic [NumSlots-1:0]  matured;
  logic                 free_found;
  logic [SlotIdxW-1:0]  free_idx;
  logic                 done_found;
  logic [SlotIdxW-1:0]  done_idx;
  logic                 accept;
  logic                 done_hit;

  // Matured flags and release vector come from registered state only.
  always_comb begin
    matured      = '0;
    release_en_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      matured[i] = slot_q[i].valid && (slot_q[i].cnt == '0);
      if (matured[i]) begin
        release_en_o[slot_q[i].id] = 1'b1;
      end
    end
  end

  // Lowest-index free slot and lowest-index matured slot matching the done ID.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!free_found && !slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = SlotIdxW'(i);
      end
      if (!done_found && matured[i] && (slot_q[i].id == done_id_i)) begin
        done_found = 1'b1;
        done_idx   = SlotIdxW'(i);
      end
    end
  end

  assign req_ready_o = free_found;
  assign accept      = req_valid_i && free_found;
  assign done_hit    = done_valid_i && done_found;

  // Accept targets a free slot and done targets a valid one, so they never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (accept && (free_idx == SlotIdxW'(i))) begin
          slot_q[i].valid <= 1'b1;
          slot_q[i].id    <= req_id_i;
          slot_q[i].cnt   <= req_delay_i;
        end else if (done_hit && (done_idx == SlotIdxW'(i))) begin
          slot_q[i].valid <= 1'b0;
        end else if (slot_q[i].valid && (slot_q[i].cnt != '0)) begin
          slot_q[i].cnt <= slot_q[i].cnt - DelayWidth'(1);
        end
      end
    end
  end

`ifdef SIMMEM_DELAY_RELEASER_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(NumSlots+1);
  logic [OccW-1:0] occupancy_q;

  // Simultaneous accept and free leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_q <= '0;
    end else if (accept && !done_hit) begin
      occupancy_q <= occupancy_q + OccW'(1);
    end else if (!accept && done_hit) begin
      occupancy_q <= occupancy_q - OccW'(1);
    end
  end

  assign occupancy_o = occupancy_q;
`endif

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Self-checking bench for simmem_delay_releaser against a descriptor-list reference model.
module tb_simmem_delay_releaser;

  localparam int unsigned IDW = 4;
  localparam int unsigned NS  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned NI  = 2**IDW;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [IDW-1:0]  req_id_i = '0;
  logic [DW-1:0]   req_delay_i = '0;
  logic [NI-1:0]   release_en_o;
  logic            done_valid_i = 1'b0;
  logic [IDW-1:0]  done_id_i = '0;
`ifdef SIMMEM_DELAY_RELEASER_OCCUPANCY_EN
  logic [$clog2(NS+1)-1:0] occupancy_o;
`endif

  simmem_delay_releaser #(.IDWidth(IDW), .NumSlots(NS), .DelayWidth(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_id_i     (req_id_i),
    .req_delay_i  (req_delay_i),
    .release_en_o (release_en_o),
`ifdef SIMMEM_DELAY_RELEASER_OCCUPANCY_EN
    .occupancy_o  (occupancy_o),
`endif
    .done_valid_i (done_valid_i),
    .done_id_i    (done_id_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outstanding descriptors with the absolute cycle they mature in.
  typedef struct {
    int id;
    int mat;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NI-1:0] exp_release();
    logic [NI-1:0] r = '0;
    foreach (q[k]) if (q[k].mat <= cyc) r[q[k].id] = 1'b1;
    return r;
  endfunction

  task automatic check_outputs();
    logic [NI-1:0] er;
    logic          erdy;
    er   = exp_release();
    erdy = (q.size() < NS);
    checks++;
    assert (release_en_o === er) else begin
      errors++;
      $error("FAIL release cyc=%0d got %h exp %h", cyc, release_en_o, er);
    end
    checks++;
    assert (req_ready_o === erdy) else begin
      errors++;
      $error("FAIL ready cyc=%0d got %b exp %b", cyc, req_ready_o, erdy);
    end
`ifdef SIMMEM_DELAY_RELEASER_OCCUPANCY_EN
    checks++;
    assert (occupancy_o === ($clog2(NS+1))'(q.size())) else begin
      errors++;
      $error("FAIL occupancy cyc=%0d got %0d exp %0d", cyc, occupancy_o, q.size());
    end
`endif
  endtask

  // One cycle: drive, check, clock edge, apply the spec rules to the model.
  task automatic step(input bit rv, input int rid, input int rd, input bit dv, input int did);
    bit m_ready;
    req_valid_i  = rv;
    req_id_i     = IDW'(rid);
    req_delay_i  = DW'(rd);
    done_valid_i = dv;
    done_id_i    = IDW'(did);
    #1;
    check_outputs();
    m_ready = (q.size() < NS);
    @(posedge clk_i);
    if (dv) begin
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].id == did && q[k].mat <= cyc) begin
          q.delete(k);
          break;
        end
      end
    end
    if (rv && m_ready) q.push_back('{rid, cyc + 1 + rd});
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  function automatic int pick_matured(output int id);
    int cand[$];
    foreach (q[k]) if (q[k].mat <= cyc) cand.push_back(q[k].id);
    if (cand.size() == 0) return 0;
    id = cand[$urandom_range(cand.size() - 1)];
    return 1;
  endfunction

  task automatic drain();
    int id;
    for (int k = 0; k < 700 && q.size() > 0; k++) begin
      if (pick_matured(id) != 0) step(0, 0, 0, 1, id);
      else step(0, 0, 0, 0, 0);
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout left=%0d exp 0", q.size());
    end
  endtask

  task automatic do_reset();
    req_valid_i  = 1'b0;
    done_valid_i = 1'b0;
    rst_ni       = 1'b0;
    q.delete();
    #1;
    check_outputs();
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int id;
    int t0;
    // Reset and idle
    #2;
    check_outputs();
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    idle(5);

    // Single descriptor, delay 4
    step(1, 3, 4, 0, 0);
    idle(6);
    step(0, 0, 0, 1, 3);
    idle(2);

    // Two same-ID descriptors, delays 0 and 2
    step(1, 1, 0, 0, 0);
    step(1, 1, 2, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 1);
    idle(1);
    step(0, 0, 0, 1, 1);
    idle(2);

    // Fill all slots with maximum delay; extra requests are refused while full
    t0 = cyc;
    for (int k = 0; k < NS; k++) step(1, k + 2, 255, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 9, 1, 0, 0);
    while (cyc < t0 + 256) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2);
    step(1, 6, 3, 0, 0);
    drain();

    // Illegal done while id 5 still counting is ignored
    step(1, 5, 10, 0, 0);
    step(0, 0, 0, 1, 5);
    idle(3);
    step(0, 0, 0, 1, 5);
    idle(8);
    drain();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      bit rv;
      bit dv;
      int rd;
      rv = ($urandom_range(99) < 55);
      case ($urandom_range(9))
        0:       rd = 0;
        1:       rd = 255;
        default: rd = $urandom_range(20);
      endcase
      dv = 1'b0;
      id = 0;
      if ($urandom_range(99) < 60) dv = (pick_matured(id) != 0);
      step(rv, $urandom_range(NI - 1), rd, dv, id);
    end
    drain();

    // Reset mid-countdown with three slots valid
    step(1, 4, 200, 0, 0);
    step(1, 7, 150, 0, 0);
    step(1, 4, 100, 0, 0);
    idle(20);
    do_reset();
    idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
